// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: hazard-control bundle between the 5-stage pipeline datapath and
//          pipe_hazard_ctrl.
// Ports (signals):
//   datapath -> controller : rs_id, rt_id, rs_used, rt_used, rd_idex,
//                            memread_idex, br_taken_ex, mem_req, mem_ack
//   controller -> datapath : pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//                            exmem_en, memwb_en, stall_cnt[CNT_W], mem_timeout
//   modport master : datapath side
//   modport slave  : controller side
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             rs_used;
  logic             rt_used;
  logic [4:0]       rd_idex;
  logic             memread_idex;
  logic             br_taken_ex;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  modport master (
    output rs_id, rt_id, rs_used, rt_used, rd_idex, memread_idex,
           br_taken_ex, mem_req, mem_ack,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, stall_cnt, mem_timeout
  );

  modport slave (
    input  rs_id, rt_id, rs_used, rt_used, rd_idex, memread_idex,
           br_taken_ex, mem_req, mem_ack,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline sequencer for the 5-stage core. Handles load-use bubbles,
//          taken-branch flushes in EX and freezes the whole pipe while a
//          multi-cycle data-memory access is outstanding. Counts stall cycles
//          (saturating) and flags a sticky memory timeout.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_hazard_ctrl_if.slave (hazard inputs, enables/flushes,
//            stall_cnt, mem_timeout)
// Enables/flushes are a combinational (Mealy) decode of state and inputs;
// stall_cnt and mem_timeout are registered.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  stallCnt;
  logic              memTimeout;

  logic luHazard;
  logic freezeReq;
  logic issue;
  logic pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbEn;

  // Load-use: the ID instruction reads the (non-zero) register a load in ID/EX writes.
  assign luHazard = bus.memread_idex && (bus.rd_idex != 5'd0) &&
                    ((bus.rs_used && (bus.rs_id == bus.rd_idex)) ||
                     (bus.rt_used && (bus.rt_id == bus.rd_idex)));

  // A new access not acked in its own cycle must freeze the pipe.
  assign freezeReq = bus.mem_req && !bus.mem_ack;

  // Normal issue decode applies in RUN without a freeze, and on the release cycle.
  assign issue = ((state == RUN) && !freezeReq) ||
                 ((state == MEM_WAIT) && bus.mem_ack);

  // Enable/flush decode; branch beats load-use since the ID instruction is wrong-path.
  always_comb begin
    pcEn      = 1'b0;
    ifidEn    = 1'b0;
    ifidFlush = 1'b0;
    idexEn    = 1'b0;
    idexFlush = 1'b0;
    exmemEn   = 1'b0;
    memwbEn   = 1'b0;
    if (issue) begin
      idexEn  = 1'b1;
      exmemEn = 1'b1;
      memwbEn = 1'b1;
      if (bus.br_taken_ex) begin
        pcEn      = 1'b1;
        ifidEn    = 1'b1;
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end else if (luHazard) begin
        idexFlush = 1'b1;
      end else begin
        pcEn   = 1'b1;
        ifidEn = 1'b1;
      end
    end
  end

  // State, memory wait counter and sticky timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freezeReq) begin
            state   <= MEM_WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_W'(MAX_WAIT)) begin
            state      <= ERR;
            memTimeout <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        ERR: begin
          memTimeout <= 1'b1;
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (!pcEn && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.pc_en       = pcEn;
  assign bus.ifid_en     = ifidEn;
  assign bus.ifid_flush  = ifidFlush;
  assign bus.idex_en     = idexEn;
  assign bus.idex_flush  = idexFlush;
  assign bus.exmem_en    = exmemEn;
  assign bus.memwb_en    = memwbEn;
  assign bus.stall_cnt   = stallCnt;
  assign bus.mem_timeout = memTimeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random
// traffic; expected responses are queued by the driver and checked by a
// separate monitor.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [6:0]       en;    // {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem, memwb}
    logic [CNT_W-1:0] cnt;
    logic             to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sbQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  // Reference model: an outstanding access, how many cycles it has frozen
  // the pipe, whether the timeout fired, and the number of stalled cycles.
  bit mFrozen;
  int mFrozenCycles;
  bit mTimedOut;
  int mStalls;

  function automatic bit loadUse(input logic [4:0] rs, rt, input logic rsu, rtu,
                                 input logic [4:0] rd, input logic mr);
    return mr && rd != 0 && ((rsu && rs == rd) || (rtu && rt == rd));
  endfunction

  function automatic logic [6:0] issueDecode(input bit br, input bit lu);
    if (br)      return 7'b1111111;
    else if (lu) return 7'b0001111;
    else         return 7'b1101011;
  endfunction

  task automatic modelReset();
    mFrozen       = 0;
    mFrozenCycles = 0;
    mTimedOut     = 0;
    mStalls       = 0;
  endtask

  task automatic cyc(input logic rstv, input logic [4:0] rs, rt, input logic rsu, rtu,
                     input logic [4:0] rd, input logic mr, br, req, ack);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst_n            = rstv;
    bus.rs_id        = rs;
    bus.rt_id        = rt;
    bus.rs_used      = rsu;
    bus.rt_used      = rtu;
    bus.rd_idex      = rd;
    bus.memread_idex = mr;
    bus.br_taken_ex  = br;
    bus.mem_req      = req;
    bus.mem_ack      = ack;
    if (!rstv) modelReset();
    lu    = loadUse(rs, rt, rsu, rtu, rd, mr);
    e.cnt = CNT_W'(mStalls);
    e.to  = mTimedOut;
    if (mTimedOut)                  e.en = 7'b0;
    else if (mFrozen && !ack)       e.en = 7'b0;
    else if (!mFrozen && req && !ack) e.en = 7'b0;
    else                            e.en = issueDecode(br, lu);
    sbQ.push_back(e);
    if (rstv) begin
      if (!e.en[6] && mStalls < CNT_MAX) mStalls++;
      if (!mTimedOut) begin
        if (mFrozen) begin
          if (ack) begin
            mFrozen = 0;
          end else begin
            mFrozenCycles++;
            if (mFrozenCycles > MAX_WAIT) mTimedOut = 1;
          end
        end else if (req && !ack) begin
          mFrozen       = 1;
          mFrozenCycles = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rstPulse();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] en;
    if (sbQ.size() > 0) begin
      e  = sbQ.pop_front();
      en = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
            bus.idex_flush, bus.exmem_en, bus.memwb_en};
      nCompared++;
      if (en !== e.en) begin
        nMismatched++;
        $display("FAIL enables @%0t: got %b want %b", $time, en, e.en);
      end
      nCompared++;
      if (bus.stall_cnt !== e.cnt) begin
        nMismatched++;
        $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, bus.stall_cnt, e.cnt);
      end
      nCompared++;
      if (bus.mem_timeout !== e.to) begin
        nMismatched++;
        $display("FAIL mem_timeout @%0t: got %b want %b", $time, bus.mem_timeout, e.to);
      end
    end
  end

  initial begin
    bus.rs_id = 0; bus.rt_id = 0; bus.rs_used = 0; bus.rt_used = 0;
    bus.rd_idex = 0; bus.memread_idex = 0; bus.br_taken_ex = 0;
    bus.mem_req = 0; bus.mem_ack = 0;
    modelReset();

    // Reset state, then release.
    rstPulse();
    idle(2);

    // Load-use on rs, then on rt: one bubble each.
    cyc(1, 5, 1, 1, 1, 5, 1, 0, 0, 0);
    cyc(1, 5, 1, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 7, 1, 1, 7, 1, 0, 0, 0);
    cyc(1, 2, 7, 1, 1, 0, 0, 0, 0, 0);

    // r0 never stalls; unused operand never stalls; non-load never stalls.
    cyc(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    cyc(1, 5, 3, 0, 1, 5, 1, 0, 0, 0);
    cyc(1, 5, 5, 1, 1, 5, 0, 0, 0, 0);

    // Taken branch together with load-use: flush, no stall.
    cyc(1, 5, 1, 1, 0, 5, 1, 1, 0, 0);
    idle(1);

    // Three-cycle freeze, then release on ack.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // Same, with branch held off until the ack cycle (and lu while frozen).
    cyc(1, 4, 0, 1, 0, 4, 1, 1, 1, 0);
    cyc(1, 4, 0, 1, 0, 4, 1, 1, 1, 0);
    cyc(1, 4, 0, 1, 0, 4, 1, 0, 1, 0);
    cyc(1, 4, 0, 1, 0, 4, 1, 1, 1, 1);
    // Release with load-use on the ack cycle.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 6, 0, 1, 0, 6, 1, 0, 1, 1);
    // Same-cycle ack: no stall.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Timeout: ack never comes; ERR persists, reset clears it.
    rstPulse();
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    rstPulse();
    idle(1);

    // Saturation: 20 load-use stalls.
    for (int i = 0; i < 20; i++) cyc(1, 3, 0, 1, 0, 3, 1, 0, 0, 0);
    idle(2);

    // Reset asserted mid-freeze.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic rstv, req;
      rstv = ($urandom_range(0, 59) != 0);
      req  = ($urandom_range(0, 3) == 0);
      cyc(rstv, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0), req, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    nCompared++;
    if (sbQ.size() != 0) begin
      nMismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
